// File: rtl/hex_nibble_source_if.sv
// Control inputs and registered outputs of the hex nibble source.
// The DUT binds to the slave modport; the stimulus side binds to master.
interface hex_nibble_source_if;
   logic       ena;
   logic       step_btn;
   logic       dir;
   logic       auto_en;
   logic       load;
   logic [3:0] load_val;
   logic [3:0] nibble;
   logic       tick;
   logic       wrap;

   modport master (
      output ena, step_btn, dir, auto_en, load, load_val,
      input  nibble, tick, wrap
   );

   modport slave (
      input  ena, step_btn, dir, auto_en, load, load_val,
      output nibble, tick, wrap
   );
endinterface

// File: rtl/hex_nibble_source.sv
// Single-clock 4-bit up/down hex value source: debounced button steps,
// prescaled auto-steps and switch loads feed a registered nibble.
module hex_nibble_source #(
   parameter int DEBOUNCE_CYCLES = 16,
   parameter int PRESCALE_DIV    = 1000000,
   parameter int PRESCALE_W      = 20
) (
   input  logic               clk,
   input  logic               rst_n,
   hex_nibble_source_if.slave bus
);
   localparam int DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

   logic [1:0]            btn_sync;
   logic [1:0]            dir_sync;
   logic [1:0]            auto_sync;
   logic [1:0]            load_sync;
   logic [3:0]            lv_sync1;
   logic [3:0]            lv_sync2;
   logic                  btn_stable;
   logic                  btn_stable_q;
   logic [DB_W-1:0]       db_cnt;
   logic [PRESCALE_W-1:0] pre_cnt;
   logic                  auto_step_q;
   logic [3:0]            nibble_r;
   logic                  tick_r;
   logic                  wrap_r;

   logic                  step_btn_s;
   logic                  dir_s;
   logic                  auto_en_s;
   logic                  load_s;
   logic [3:0]            load_val_s;
   logic                  man_step;
   logic                  auto_step;
   logic                  pre_last;

   assign step_btn_s = btn_sync[1];
   assign dir_s      = dir_sync[1];
   assign auto_en_s  = auto_sync[1];
   assign load_s     = load_sync[1];
   assign load_val_s = lv_sync2;

   assign man_step  = btn_stable & ~btn_stable_q;
   assign pre_last  = (pre_cnt == PRESCALE_W'(PRESCALE_DIV - 1));
   assign auto_step = auto_en_s & pre_last;

   assign bus.nibble = nibble_r;
   assign bus.tick   = tick_r;
   assign bus.wrap   = wrap_r;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         btn_sync     <= '0;
         dir_sync     <= '0;
         auto_sync    <= '0;
         load_sync    <= '0;
         lv_sync1     <= '0;
         lv_sync2     <= '0;
         btn_stable   <= 1'b0;
         btn_stable_q <= 1'b0;
         db_cnt       <= '0;
         pre_cnt      <= '0;
         auto_step_q  <= 1'b0;
         nibble_r     <= '0;
         tick_r       <= 1'b0;
         wrap_r       <= 1'b0;
      end else if (bus.ena) begin
         btn_sync  <= {btn_sync[0], bus.step_btn};
         dir_sync  <= {dir_sync[0], bus.dir};
         auto_sync <= {auto_sync[0], bus.auto_en};
         load_sync <= {load_sync[0], bus.load};
         lv_sync1  <= bus.load_val;
         lv_sync2  <= lv_sync1;

         if (step_btn_s == btn_stable) begin
            db_cnt <= '0;
         end else if (db_cnt == DB_W'(DEBOUNCE_CYCLES - 1)) begin
            btn_stable <= step_btn_s;
            db_cnt     <= '0;
         end else begin
            db_cnt <= db_cnt + DB_W'(1);
         end
         btn_stable_q <= btn_stable;

         if (!auto_en_s || pre_last) begin
            pre_cnt <= '0;
         end else begin
            pre_cnt <= pre_cnt + PRESCALE_W'(1);
         end
         // Auto strobe is registered so the first step lands DIV+3 edges
         // after auto_en rises, matching the button path's edge-detect delay.
         auto_step_q <= auto_step;

         if (load_s) begin
            nibble_r <= load_val_s;
            tick_r   <= (load_val_s != nibble_r);
            wrap_r   <= 1'b0;
         end else if (man_step || auto_step_q) begin
            tick_r <= 1'b1;
            if (dir_s) begin
               nibble_r <= nibble_r + 4'd1;
               wrap_r   <= (nibble_r == 4'hF);
            end else begin
               nibble_r <= nibble_r - 4'd1;
               wrap_r   <= (nibble_r == 4'h0);
            end
         end else begin
            tick_r <= 1'b0;
            wrap_r <= 1'b0;
         end
      end
   end
endmodule

// File: tb/tb_hex_nibble_source.sv
// Directed bench for hex_nibble_source: an input-history model predicts
// nibble/tick/wrap each cycle, and literal checks pin the key scenarios.
module tb_hex_nibble_source;
   localparam int D    = 4;
   localparam int DIV  = 8;
   localparam int NMAX = 4096;

   logic clk = 1'b0;
   logic rst_n;
   int   n_cmp = 0;
   int   n_bad = 0;

   hex_nibble_source_if bus ();

   hex_nibble_source #(
      .DEBOUNCE_CYCLES(D),
      .PRESCALE_DIV(DIV),
      .PRESCALE_W(3)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .bus(bus)
   );

   always #5 clk = ~clk;

   // Raw input history, indexed by enabled edges since reset (1-based).
   logic       raw_btn  [0:NMAX-1];
   logic       raw_dir  [0:NMAX-1];
   logic       raw_auto [0:NMAX-1];
   logic       raw_load [0:NMAX-1];
   logic [3:0] raw_lv   [0:NMAX-1];
   logic       rose     [0:NMAX-1];
   int         t = 0;
   logic       m_stable = 1'b0;
   logic [3:0] m_nib = 4'd0;
   logic       m_tick = 1'b0;
   logic       m_wrap = 1'b0;

   function automatic logic btn_at(int i);
      return (i >= 1) ? raw_btn[i] : 1'b0;
   endfunction
   function automatic logic dir_at(int i);
      return (i >= 1) ? raw_dir[i] : 1'b0;
   endfunction
   function automatic logic auto_at(int i);
      return (i >= 1) ? raw_auto[i] : 1'b0;
   endfunction
   function automatic logic load_at(int i);
      return (i >= 1) ? raw_load[i] : 1'b0;
   endfunction
   function automatic logic [3:0] lv_at(int i);
      return (i >= 1) ? raw_lv[i] : 4'd0;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Model: a press is accepted once D consecutive synchronized samples
   // (raw delayed by two edges) disagree with the accepted level; the step
   // follows one edge later. An auto step lands when the run of raw auto_en
   // highs ending three edges back is a nonzero multiple of DIV.
   initial begin
      rose[0] = 1'b0;
      forever begin
         @(posedge clk or negedge rst_n);
         if (!rst_n) begin
            t = 0; m_stable = 1'b0; m_nib = 4'd0; m_tick = 1'b0; m_wrap = 1'b0;
            rose[0] = 1'b0;
         end else if (bus.ena) begin
            logic flip, man, aut, ld, dr;
            int   run;
            t++;
            if (t >= NMAX) begin
               $display("FAIL model_history: index %0d exceeds %0d", t, NMAX);
               $fatal(1);
            end
            raw_btn[t] = bus.step_btn;  raw_dir[t] = bus.dir;
            raw_auto[t] = bus.auto_en;  raw_load[t] = bus.load;
            raw_lv[t] = bus.load_val;
            flip = 1'b1;
            for (int j = t - 1 - D; j <= t - 2; j++)
               if (btn_at(j) == m_stable) flip = 1'b0;
            rose[t] = flip && !m_stable;
            if (flip) m_stable = ~m_stable;
            man = rose[t-1];
            run = 0;
            for (int j = t - 3; j >= 1; j--) begin
               if (!auto_at(j)) break;
               run++;
            end
            aut = (run > 0) && (run % DIV == 0);
            ld = load_at(t - 2);
            dr = dir_at(t - 2);
            if (ld) begin
               m_tick = (lv_at(t - 2) != m_nib);
               m_wrap = 1'b0;
               m_nib  = lv_at(t - 2);
            end else if (man || aut) begin
               m_tick = 1'b1;
               m_wrap = dr ? (m_nib == 4'd15) : (m_nib == 4'd0);
               m_nib  = dr ? m_nib + 4'd1 : m_nib - 4'd1;
            end else begin
               m_tick = 1'b0;
               m_wrap = 1'b0;
            end
         end
      end
   end

   initial begin
      forever begin
         @(negedge clk);
         chk("model_nibble", bus.nibble, m_nib);
         chk("model_tick", bus.tick, m_tick);
         chk("model_wrap", bus.wrap, m_wrap);
      end
   end

   int   dut_ticks = 0;
   int   dut_wraps = 0;
   logic en_edge = 1'b0;
   initial forever begin
      @(posedge clk);
      en_edge = bus.ena;
   end
   initial forever begin
      @(negedge clk);
      if (!rst_n) begin
         dut_ticks = 0;
         dut_wraps = 0;
      end else if (en_edge) begin
         if (bus.tick) dut_ticks++;
         if (bus.wrap) dut_wraps++;
      end
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation exceeded time limit");
      $fatal(1);
   end

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      @(negedge clk);
   endtask

   initial begin
      int w0;
      rst_n = 1'b0;
      bus.ena = 1'b1; bus.step_btn = 1'b0; bus.dir = 1'b1; bus.auto_en = 1'b0;
      bus.load = 1'b0; bus.load_val = 4'd0;
      repeat (3) @(negedge clk);
      chk("reset_nibble", bus.nibble, 4'd0);
      chk("reset_tick", bus.tick, 1'b0);
      chk("reset_wrap", bus.wrap, 1'b0);
      rst_n = 1'b1;
      step(4);

      // single press, held 10 cycles
      bus.step_btn = 1'b1;
      step(6);  chk("press_before", bus.nibble, 4'd0);
      step(1);  chk("press_nibble", bus.nibble, 4'd1);
      chk("press_tick", bus.tick, 1'b1);
      step(1);  chk("press_tick_end", bus.tick, 1'b0);
      step(2);
      bus.step_btn = 1'b0;
      step(12);
      chk("release_hold", bus.nibble, 4'd1);
      chk("press_tick_count", dut_ticks, 1);

      // bounce: 2-cycle pulses, then a steady press
      for (int i = 0; i < 5; i++) begin
         bus.step_btn = 1'b1; step(2);
         bus.step_btn = 1'b0; step(2);
      end
      bus.step_btn = 1'b1;
      step(6);  chk("bounce_before", bus.nibble, 4'd1);
      step(1);  chk("bounce_step", bus.nibble, 4'd2);
      bus.step_btn = 1'b0;
      step(12);

      // wrap up 15 -> 0
      bus.load_val = 4'd15; bus.load = 1'b1;
      step(3);  chk("load_15", bus.nibble, 4'd15);
      chk("load_tick", bus.tick, 1'b1);
      bus.load = 1'b0;
      step(4);
      bus.step_btn = 1'b1;
      step(7);  chk("wrap_up_nibble", bus.nibble, 4'd0);
      chk("wrap_up_tick", bus.tick, 1'b1);
      chk("wrap_up_wrap", bus.wrap, 1'b1);
      step(1);  chk("wrap_up_pulse_end", bus.wrap, 1'b0);
      bus.step_btn = 1'b0;
      step(10);

      // wrap down 0 -> 15
      bus.dir = 1'b0;
      step(3);
      bus.step_btn = 1'b1;
      step(7);  chk("wrap_dn_nibble", bus.nibble, 4'd15);
      chk("wrap_dn_wrap", bus.wrap, 1'b1);
      bus.step_btn = 1'b0;
      step(10);

      // auto-step from 0, 16 steps
      bus.load_val = 4'd0; bus.load = 1'b1;
      step(3);
      bus.load = 1'b0; bus.dir = 1'b1;
      step(4);  chk("auto_start", bus.nibble, 4'd0);
      w0 = dut_wraps;
      bus.auto_en = 1'b1;
      step(10); chk("auto_before", bus.nibble, 4'd0);
      step(1);  chk("auto_first", bus.nibble, 4'd1);
      chk("auto_first_tick", bus.tick, 1'b1);
      for (int i = 2; i <= 16; i++) begin
         step(8);
         chk("auto_step", bus.nibble, 32'(i % 16));
      end
      chk("auto_wrap_count", dut_wraps - w0, 1);
      bus.auto_en = 1'b0;
      step(12);

      // load dominates press and auto-step
      bus.load_val = 4'd9; bus.load = 1'b1;
      step(3);
      w0 = dut_wraps;
      bus.step_btn = 1'b1; bus.auto_en = 1'b1;
      step(20); chk("prio_nibble", bus.nibble, 4'd9);
      chk("prio_no_wrap", dut_wraps - w0, 0);
      bus.load = 1'b0; bus.step_btn = 1'b0; bus.auto_en = 1'b0;
      step(12); chk("prio_after", bus.nibble, 4'd9);

      // press and auto-step landing on the same edge
      bus.auto_en = 1'b1;
      step(4);
      bus.step_btn = 1'b1;
      step(6);  chk("coinc_before", bus.nibble, 4'd9);
      step(1);  chk("coinc_step", bus.nibble, 4'd10);
      bus.step_btn = 1'b0; bus.auto_en = 1'b0;
      step(12); chk("coinc_single", bus.nibble, 4'd10);

      // ena dropped mid-debounce for 5 cycles
      bus.step_btn = 1'b1;
      step(3);
      bus.ena = 1'b0;
      step(5);
      bus.ena = 1'b1;
      step(3);  chk("freeze_before", bus.nibble, 4'd10);
      step(1);  chk("freeze_step", bus.nibble, 4'd11);
      bus.step_btn = 1'b0;
      step(10);

      // asynchronous reset mid-prescale
      bus.auto_en = 1'b1;
      step(5);
      #2 rst_n = 1'b0;
      #1;
      chk("rst_async_nibble", bus.nibble, 4'd0);
      chk("rst_async_tick", bus.tick, 1'b0);
      chk("rst_async_wrap", bus.wrap, 1'b0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      step(10); chk("rst_auto_before", bus.nibble, 4'd0);
      step(1);  chk("rst_auto_first", bus.nibble, 4'd1);
      bus.auto_en = 1'b0;
      step(4);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/hex_nibble_source.md
# hex_nibble_source

Synchronous 4-bit hex value generator feeding the 7-segment nibble decoder stage. It replaces a ripple-clocked counter with a single-clock design. The value advances from a debounced pushbutton or from an internal prescaled auto-tick, counts up or down, and can be loaded from switches. The `nibble` output drives the decoder's counter-side mux input directly.

## Interface

**Parameters**

- `DEBOUNCE_CYCLES`, default 16: consecutive stable synchronized samples required to accept a button level change. Must be ≥2.
- `PRESCALE_DIV`, default 1000000: clock cycles per auto-tick. Must be ≥2.
- `PRESCALE_W`, default 20: prescaler width. Must satisfy 2^PRESCALE_W ≥ PRESCALE_DIV.

**Ports**

- `clk` input 1: single clock, rising edge.
- `rst_n` input 1: reset, asynchronous, active-low.
- `ena` input 1: when 0, all state freezes.
- `step_btn` input 1: raw pushbutton, asynchronous, bouncy.
- `dir` input 1: direction, 1 = up, 0 = down.
- `auto_en` input 1: enables prescaled free-run stepping.
- `load` input 1: level load request.
- `load_val` input 4: switch value to load.
- `nibble` output 4: current value, registered.
- `tick` output 1: one-cycle pulse, registered; high in the cycle `nibble` shows a changed value.
- `wrap` output 1: one-cycle pulse, registered; high with `tick` when a step wrapped 15→0 (up) or 0→15 (down).

## Operation

**Input synchronization**
- `step_btn`, `dir`, `auto_en`, `load` and `load_val` each pass through 2-flop synchronizers. All logic uses only the synchronized versions (`*_s`).

**Debounce**
- State is `btn_stable` plus counter `db_cnt`.
- If `step_btn_s == btn_stable`, then `db_cnt <= 0`.
- Otherwise:
  - if `db_cnt == DEBOUNCE_CYCLES-1`: `btn_stable <= step_btn_s` and `db_cnt <= 0`;
  - else: `db_cnt++`.
- `man_step = btn_stable & ~btn_stable_q`, a rising-edge detect. Release generates no step.

**Prescaler**
- When `auto_en_s == 0`, `pre_cnt` is held at 0.
- When `auto_en_s == 1`, `pre_cnt` counts 0..PRESCALE_DIV-1 and then wraps to 0.
- `auto_step = auto_en_s & (pre_cnt == PRESCALE_DIV-1)`.

**Counter update** (priority top to bottom)
1. `load_s == 1`: `nibble <= load_val_s`. Any steps in this cycle are discarded, not queued. `tick` is high if the new value differs from the old one. `wrap = 0`.
2. `man_step | auto_step`: `nibble <= nibble ± 1 mod 16`, using `dir_s`. A coincident manual and auto step produce exactly one step. `tick = 1`. `wrap = 1` on 15→0 (up) or 0→15 (down).
3. Otherwise: hold, with `tick = 0` and `wrap = 0`.

**Enable**
- `ena == 0`: no register updates, including synchronizers, debounce, prescaler, `nibble`, `tick` and `wrap`. Outputs hold their last values.

**Reset**
- Reset is asynchronous. All registers return to their reset values immediately, including mid-debounce and mid-prescale. No step is pending after release.
- Reset values: `nibble = 0`, `tick = 0`, `wrap = 0`, `btn_stable = 0`, `db_cnt = 0`, `pre_cnt = 0`, all synchronizer flops 0.

## Timing

Edge numbering: edge 1 is the first rising edge that samples a new raw input level. All figures assume `ena = 1`.

- **Button:** `step_btn_s` changes at edge 2 and `btn_stable` at edge 2+DEBOUNCE_CYCLES. `nibble`, `tick` and `wrap` update at edge 3+DEBOUNCE_CYCLES.
- **Short pulses:** a raw level held for fewer than DEBOUNCE_CYCLES+2 edges may be rejected. A level whose synchronized version lasts fewer than DEBOUNCE_CYCLES cycles is always rejected.
- **Load:** `nibble` reflects `load_val` at edge 3 after `load` rises. While `load` stays high, `nibble` tracks `load_val` with 3-edge latency.
- **Auto-step:** with `auto_en` steady high, the first step lands PRESCALE_DIV+3 edges after `auto_en` rises. Subsequent steps come every PRESCALE_DIV cycles exactly.
- **Direction:** `dir` changes take effect 2 edges after the raw change. A step in the same cycle uses the synchronized `dir_s`.
- **Pulse width:** `tick` and `wrap` are each exactly one cycle wide per event.

## Test plan

Bench parameters: DEBOUNCE_CYCLES=4, PRESCALE_DIV=8, PRESCALE_W=3.

- **Reset, then press:** after reset, hold `step_btn` high for 10 cycles with `dir=1` → `nibble` goes 0→1 at edge 7 with a single `tick`. Release → no further change.
- **Bounce rejection:** toggle `step_btn` every 2 cycles for 20 cycles, then hold high → exactly one increment, landing 7 edges after the final rise.
- **Wrap both directions:**
  - load 15, release `load`, then one press with `dir=1` → `nibble` = 0 with `tick=1` and `wrap=1` for one cycle.
  - with `dir=0`, one press → `nibble` = 15 with `wrap=1`.
- **Auto-step:** `auto_en=1` with `dir=1` from 0 → `nibble` = 1 at edge 11, then increments every 8 cycles. After 16 steps it is back at 0, with `wrap` seen once.
- **Priority and coincidence:**
  - hold `load=1` with `load_val=9` while a press and an auto-step occur → `nibble` stays 9 and no `wrap`.
  - a press and an auto-step in the same cycle → exactly one increment.
- **Freeze and reset:**
  - drop `ena` mid-debounce for 5 cycles → the step lands 5 cycles later than nominal.
  - assert `rst_n=0` mid-prescale → `nibble`, `tick` and `wrap` go to 0 immediately, and the first auto-step after release again takes 11 edges.
